// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU controller: FSM state encoding and
// instruction field positions.
package hack_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    READ_M  = 3'd2,
    EXEC    = 3'd3,
    WRITE_M = 3'd4
  } state_t;

  localparam int TYPE   = 15;
  localparam int ABIT   = 12;
  localparam int CMP_HI = 11;
  localparam int CMP_LO = 6;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;
  localparam int JLT    = 2;
  localparam int JEQ    = 1;
  localparam int JGT    = 0;

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// Controller-side bus bundle: instruction fetch, data memory and ALU operand/result
// signals. master = controller, slave = memories + ALU.
interface hack_cpu_ctrl_if #(
  parameter int PC_W = 15,
  parameter int W    = 16
);
  logic            instr_req;
  logic [PC_W-1:0] instr_addr;
  logic            instr_ack;
  logic [W-1:0]    instr_data;

  logic            mem_rd_req;
  logic            mem_wr;
  logic [PC_W-1:0] mem_addr;
  logic [W-1:0]    mem_wdata;
  logic [W-1:0]    mem_rdata;
  logic            mem_ack;

  logic [W-1:0]    alu_x;
  logic [W-1:0]    alu_y;
  logic            alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [W-1:0]    alu_out;
  logic            alu_zr;
  logic            alu_ng;

  modport master (
    output instr_req, instr_addr, input instr_ack, instr_data,
    output mem_rd_req, mem_wr, mem_addr, mem_wdata, input mem_rdata, mem_ack,
    output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    input  alu_out, alu_zr, alu_ng
  );

  modport slave (
    input  instr_req, instr_addr, output instr_ack, instr_data,
    input  mem_rd_req, mem_wr, mem_addr, mem_wdata, output mem_rdata, mem_ack,
    input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    output alu_out, alu_zr, alu_ng
  );
endinterface

// File: rtl/hack_jump_unit.sv
// Hack jump condition: j bits select less-than / equal / greater-than zero.
module hack_jump_unit
  import hack_pkg::*;
(
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       jump
);
  assign jump = (j[JLT] & ng) | (j[JEQ] & zr) | (j[JGT] & ~ng & ~zr);
endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU controller: fetch/decode, ALU operand drive, A/D/PC
// ownership and req/ack sequencing toward instruction and data memory.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int PC_W = 15,
  parameter int W    = 16
) (
  input  logic            clock,
  input  logic            reset,
  hack_cpu_ctrl_if.master bus,
  output logic [PC_W-1:0] pc
);

  state_t         state;
  logic [W-1:0]   ir;
  logic [W-1:0]   a;
  logic [W-1:0]   d;
  logic [W-1:0]   m_q;
  logic [W-1:0]   wdata_q;
  logic           zr_q, ng_q;

  logic           in_wr;
  logic           flag_zr, flag_ng;
  logic           jump;
  logic [W-1:0]   res;

  // Requests decode from state, gated by reset so they drop the instant reset rises.
  assign bus.instr_req  = (state == FETCH)   & ~reset;
  assign bus.mem_rd_req = (state == READ_M)  & ~reset;
  assign bus.mem_wr     = (state == WRITE_M) & ~reset;
  assign bus.instr_addr = pc;
  assign bus.mem_addr   = a[PC_W-1:0];
  assign bus.mem_wdata  = wdata_q;

  assign bus.alu_x  = d;
  assign bus.alu_y  = ir[ABIT] ? m_q : a;
  assign {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} = ir[CMP_HI:CMP_LO];

  // During WRITE_M the result and flags come from the EXEC-cycle snapshot.
  assign in_wr   = (state == WRITE_M);
  assign flag_zr = in_wr ? zr_q : bus.alu_zr;
  assign flag_ng = in_wr ? ng_q : bus.alu_ng;
  assign res     = in_wr ? wdata_q : bus.alu_out;

  hack_jump_unit u_jump (
    .j    (ir[JLT:JGT]),
    .zr   (flag_zr),
    .ng   (flag_ng),
    .jump (jump)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= '0;
      a       <= '0;
      d       <= '0;
      ir      <= '0;
      m_q     <= '0;
      wdata_q <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      case (state)
        FETCH: if (bus.instr_ack) begin
          ir    <= bus.instr_data;
          state <= DECODE;
        end
        DECODE: begin
          if (!ir[TYPE]) begin
            a     <= {{(W-PC_W){1'b0}}, ir[PC_W-1:0]};
            pc    <= pc + 1'b1;
            state <= FETCH;
          end else begin
            state <= ir[ABIT] ? READ_M : EXEC;
          end
        end
        READ_M: if (bus.mem_ack) begin
          m_q   <= bus.mem_rdata;
          state <= EXEC;
        end
        EXEC: begin
          if (ir[DEST_M]) begin
            wdata_q <= bus.alu_out;
            zr_q    <= bus.alu_zr;
            ng_q    <= bus.alu_ng;
            state   <= WRITE_M;
          end else begin
            if (ir[DEST_A]) a <= res;
            if (ir[DEST_D]) d <= res;
            pc    <= jump ? a[PC_W-1:0] : pc + 1'b1;
            state <= FETCH;
          end
        end
        WRITE_M: if (bus.mem_ack) begin
          // Jump target is the A value from before this instruction's A write.
          if (ir[DEST_A]) a <= res;
          if (ir[DEST_D]) d <= res;
          pc    <= jump ? a[PC_W-1:0] : pc + 1'b1;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl: behavioural Hack ALU plus req/ack memory servicing.
module tb_hack_cpu_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] pc;

  hack_cpu_ctrl_if #(.PC_W(15), .W(16)) bus ();

  hack_cpu_ctrl #(.PC_W(15), .W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .pc    (pc)
  );

  always #5 clock = ~clock;

  // Reference Hack ALU
  always_comb begin
    logic [15:0] x, y, o;
    x = bus.alu_zx ? 16'h0 : bus.alu_x;
    x = bus.alu_nx ? ~x : x;
    y = bus.alu_zy ? 16'h0 : bus.alu_y;
    y = bus.alu_ny ? ~y : y;
    o = bus.alu_f ? x + y : x & y;
    o = bus.alu_no ? ~o : o;
    bus.alu_out = o;
    bus.alu_zr  = (o == 16'h0);
    bus.alu_ng  = o[15];
  end

  int n_chk = 0;
  int n_pass = 0;

  logic        rd_seen, wr_seen;
  logic [14:0] rd_addr, wr_addr;
  logic [15:0] wr_data, exec_y;
  logic [5:0]  exec_ctrl;
  int          wr_cycles, last_cycles;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic fetch_word(input logic [15:0] word);
    int n;
    n = 0;
    while (!bus.instr_req && n < 20) begin @(negedge clock); n++; end
    if (!bus.instr_req) chk("fetch_timeout", 0, 1);
    bus.instr_ack  = 1'b1;
    bus.instr_data = word;
    @(negedge clock);
    bus.instr_ack  = 1'b0;
  endtask

  // Executes one instruction; data accesses are acked after dly extra cycles.
  task automatic run_instr(input logic [15:0] word, input int dly, input logic [15:0] rdata);
    int n, cyc;
    rd_seen = 0; wr_seen = 0; wr_cycles = 0;
    fetch_word(word);
    cyc = 1; n = 0;
    while (!bus.instr_req && cyc < 40) begin
      if (bus.mem_rd_req) begin
        rd_seen = 1; rd_addr = bus.mem_addr;
        bus.mem_rdata = rdata;
        bus.mem_ack = (n == dly);
        n = (n == dly) ? 0 : n + 1;
      end else if (bus.mem_wr) begin
        wr_seen = 1; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata; wr_cycles++;
        bus.mem_ack = (n == dly);
        n = (n == dly) ? 0 : n + 1;
      end else begin
        bus.mem_ack = 1'b0;
        exec_ctrl = {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no};
        exec_y = bus.alu_y;
      end
      @(negedge clock);
      cyc++;
    end
    bus.mem_ack = 1'b0;
    if (cyc >= 40) chk("instr_timeout", 0, 1);
    last_cycles = cyc;
  endtask

  initial begin
    int n;
    bus.instr_ack = 0; bus.instr_data = '0; bus.mem_ack = 0; bus.mem_rdata = '0;

    #3;
    chk("rst_instr_req", bus.instr_req, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_a", bus.mem_addr, 0);
    chk("rst_d", bus.alu_x, 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    #1 chk("post_rst_fetch", {bus.instr_req, bus.instr_addr}, {1'b1, 15'h0});

    // @5
    run_instr(16'h0005, 0, 16'h0);
    chk("ainst_cycles", last_cycles, 2);
    chk("ainst_a", bus.mem_addr, 15'h5);
    chk("ainst_pc", pc, 15'd1);
    chk("ainst_no_data", {rd_seen, wr_seen}, 2'b00);

    // D=A
    run_instr(16'hEC10, 0, 16'h0);
    chk("da_ctrl", exec_ctrl, 6'b110000);
    chk("da_y", exec_y, 16'h5);
    chk("da_d", bus.alu_x, 16'h5);
    chk("da_pc", pc, 15'd2);
    chk("da_cycles", last_cycles, 3);

    // M=D+1 with ack delayed 3 cycles
    run_instr(16'hE7C8, 3, 16'h0);
    chk("mw_hold", wr_cycles, 4);
    chk("mw_addr", wr_addr, 15'h5);
    chk("mw_data", wr_data, 16'h6);
    chk("mw_a", bus.mem_addr, 15'h5);
    chk("mw_d", bus.alu_x, 16'h5);
    chk("mw_pc", pc, 15'd3);
    chk("mw_cycles", last_cycles, 7);

    // D;JGT taken with D=5
    run_instr(16'h0010, 0, 16'h0);
    run_instr(16'hE301, 0, 16'h0);
    chk("jgt_taken", pc, 15'h10);

    // D=0 -> not taken
    run_instr(16'h0000, 0, 16'h0);
    run_instr(16'hEC10, 0, 16'h0);
    run_instr(16'h0010, 0, 16'h0);
    chk("jgt_pre_pc", pc, 15'h13);
    run_instr(16'hE301, 0, 16'h0);
    chk("jgt_not_taken", pc, 15'h14);

    // 0;JMP to 0x7FFF, then non-jumping instruction wraps pc
    run_instr(16'h7FFF, 0, 16'h0);
    run_instr(16'hEA87, 0, 16'h0);
    chk("jmp_7fff", pc, 15'h7FFF);
    run_instr(16'hE301, 0, 16'h0);
    chk("pc_wrap", pc, 15'h0);

    // AM=M-1 with mem[7]=3
    run_instr(16'h0007, 0, 16'h0);
    run_instr(16'hFCA8, 0, 16'h3);
    chk("amm_rd_addr", {rd_seen, rd_addr}, {1'b1, 15'h7});
    chk("amm_wr_addr", {wr_seen, wr_addr}, {1'b1, 15'h7});
    chk("amm_wr_data", wr_data, 16'h2);
    chk("amm_a", bus.mem_addr, 15'h2);
    chk("amm_d", bus.alu_x, 16'h0);
    chk("amm_cycles", last_cycles, 5);

    // Reset in the middle of a pending write
    fetch_word(16'hE7C8);
    n = 0;
    while (!bus.mem_wr && n < 10) begin @(negedge clock); n++; end
    chk("rst_wr_pending", bus.mem_wr, 1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_wr_drop", bus.mem_wr, 0);
    chk("rst_req_drop", bus.instr_req, 0);
    chk("rst_mid_pc", pc, 0);
    chk("rst_mid_a", bus.mem_addr, 0);
    chk("rst_mid_d", bus.alu_x, 0);
    chk("rst_mid_wdata", bus.mem_wdata, 0);
    @(posedge clock);
    #1 bus.mem_ack = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    chk("rst_next_fetch", {bus.instr_req, bus.instr_addr, bus.mem_wr, bus.mem_rd_req},
        {1'b1, 15'h0, 1'b0, 1'b0});
    run_instr(16'h0003, 0, 16'h0);
    chk("rst_resume_a", bus.mem_addr, 15'h3);
    chk("rst_resume_pc", pc, 15'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
- Multi-cycle Hack CPU controller. It is the producer side of the ALU interface: it fetches and decodes each instruction and drives the ALU operands and the zx/nx/zy/ny/f/no controls.
- It consumes the ALU's out/zr/ng results for destination writes and jump decisions.
- It owns the A, D and PC registers and talks to instruction and data memory over req/ack handshakes.

Parameters:
- PC_W, 15, program counter and memory address width.
- W, 16, data and instruction width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_req  out  1  instruction fetch request.
- instr_addr  out  PC_W  fetch address; equals pc.
- instr_ack  in  1  instruction data valid this cycle.
- instr_data  in  W  instruction word.
- mem_rd_req  out  1  data read request.
- mem_wr  out  1  data write request.
- mem_addr  out  PC_W  data address; equals A[14:0].
- mem_wdata  out  W  write data.
- mem_rdata  in  W  read data; valid when mem_ack is high.
- mem_ack  in  1  data access complete.
- alu_x  out  W  ALU x operand; always D.
- alu_y  out  W  ALU y operand; M latch if IR[12]=1, else A.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  equal IR[11:6] in that order.
- alu_out  in  W  ALU result.
- alu_zr  in  1  ALU result is zero.
- alu_ng  in  1  ALU result is negative.
- pc  out  PC_W  current program counter.

Behaviour:
- Reset is asynchronous and active-high. On reset: state=FETCH, pc=0, A=0, D=0, IR=0, M latch=0, mem_wdata=0. instr_req, mem_rd_req and mem_wr go low immediately, not at the next clock edge.
- Any access in flight when reset asserts is abandoned. No write completes after reset asserts.
- FETCH:
  - instr_req=1.
  - On a clock edge with instr_ack=1: IR<=instr_data, go DECODE.
  - Otherwise stay in FETCH with instr_req held high.
- DECODE:
  - If IR[15]=0 (A-instruction): A<=zero-extended IR[14:0], pc<=pc+1, go FETCH.
  - If IR[15]=1 and IR[12]=1: go READ_M.
  - If IR[15]=1 and IR[12]=0: go EXEC.
  - IR[14:13] are ignored.
- READ_M:
  - mem_rd_req=1 and mem_addr=A.
  - On a clock edge with mem_ack=1: M latch<=mem_rdata, go EXEC.
- EXEC:
  - The ALU is combinational, so alu_out/zr/ng are sampled in this same cycle.
  - jump = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~ng&~zr).
  - If IR[3]=1: mem_wdata<=alu_out, latch jump, zr and ng, go WRITE_M.
  - Else apply the update step, go FETCH.
- WRITE_M:
  - mem_wr=1, mem_addr=old A, mem_wdata held stable.
  - On a clock edge with mem_ack=1: apply the update step, go FETCH.
- Update step, all in one clock edge:
  - If IR[5]: A<=alu_out.
  - If IR[4]: D<=alu_out.
  - pc <= jump ? old A[14:0] : pc+1.
  - The jump target is A from before this instruction's A write.
- pc wraps from 0x7FFF to 0x0000.
- Latency with ack in the same cycle as the request:
  - A-instruction: 2 cycles.
  - C-instruction without M read or write: 3 cycles.
  - Each M read or M write adds 1 cycle plus the ack wait.
- Handshake rules:
  - At most one request output is high in any cycle.
  - A request stays high until its ack is seen.
  - An ack seen in any state other than the waiting state is ignored.

Decomposition:
- Shared package hack_pkg holds:
  - the state encoding (FETCH, DECODE, READ_M, EXEC, WRITE_M);
  - instruction field positions: TYPE=15, ABIT=12, CMP=11:6, DEST_A=5, DEST_D=4, DEST_M=3, JLT=2, JEQ=1, JGT=0.
- One combinational sub-module, hack_jump_unit, with inputs j[2:0], zr, ng and output jump.

Test Plan:
- Reset, then fetch 0x0005 with immediate ack -> after 2 cycles A=0x0005, pc=1, no data request.
- @5 then 0xEC10 (D=A) -> during EXEC alu_zx..alu_no=110000 and alu_y=5; afterwards D=5, pc=2.
- A=5, D=5, then 0xE7C8 (M=D+1), mem_ack delayed 3 cycles -> mem_wr held 4 cycles with mem_addr=5 and mem_wdata=6; A and D unchanged; pc advances only after the ack.
- 0xE301 (D;JGT) with A=0x0010:
  - D=5 -> pc=0x0010.
  - D=0 -> pc=old pc+1.
  - At pc=0x7FFF with no jump -> pc=0x0000.
- A=7, mem[7]=3, then 0xFCA8 (AM=M-1) -> read at address 7, write at address 7 with data 2, then A=2.
- Assert reset in the middle of WRITE_M -> mem_wr drops in the same cycle; pc=0, A=0, D=0; the next request after release is a fetch at address 0.
